bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning the number of 32-bit RAM words; it is a power of two, at most 2^20.
REQ-002 SHALL have parameter MMIO_BASE, default 32'hFFFF_FF00, meaning the byte address of the MMIO window.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of TX FIFO entries; it is a power of two, from 2 to 15.
REQ-004 SHALL have port: clk  input  1  system clock; all state updates on the rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port: mem_addr  input  32  byte address from the core.
REQ-007 SHALL have port: mem_data  inout  32  shared data bus.
REQ-008 SHALL have port: mem_rw  input  1  1 = write, 0 = read.
REQ-009 SHALL have port: mem_size  input  2  0 = idle, 1 = byte, 2 = halfword, 3 = word.
REQ-010 SHALL have port: tx_data  output  8  FIFO head byte.
REQ-011 SHALL have port: tx_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port: tx_ready  input  1  downstream accepts the head byte.
REQ-013 SHALL have port: err  output  1  sticky access-error flag.

Function
REQ-014 SHALL treat a cycle as an access when mem_size != 0; when mem_size == 0, nothing changes and mem_data is high-Z.
REQ-015 SHALL decode RAM as mem_addr < RAM_WORDS*4; TXDATA as MMIO_BASE+0; STATUS as MMIO_BASE+4; every other address is unmapped.
REQ-016 SHALL flag an access as misaligned when it is a halfword with addr[0]=1, or a word with addr[1:0] != 0.
REQ-017 SHALL drive mem_data combinationally on a read access, and hold it high-Z at all other times, including during writes.
REQ-018 SHALL return RAM read data little-endian, right-aligned, and zero-extended; the byte/halfword lane is selected by addr[1:0].
REQ-019 SHALL perform a RAM write at the clock edge, storing only the lanes selected by mem_size and addr[1:0], taken from the low bits of mem_data; all other lanes are unchanged.
REQ-020 SHALL, on a write to TXDATA of any size, push mem_data[7:0] into the FIFO.
REQ-021 SHALL read STATUS as: bit0 = full; bit1 = empty; bits[7:4] = count; bit8 = err; all other bits 0.
REQ-022 SHALL clear err on a write to STATUS with mem_data[8] = 1; all other STATUS write bits are ignored.
REQ-023 SHALL read TXDATA as 0.
REQ-024 SHALL, on a misaligned or unmapped access: ignore a write, return 0 for a read, and set err at the next edge.
REQ-025 SHALL set err at the edge when a push is dropped because the FIFO is full and no pop occurs that cycle.
REQ-026 SHALL give err-set priority over err-clear when both occur in the same cycle (impossible with a single access; enforced anyway).
REQ-027 SHALL drive tx_valid = (count != 0) and tx_data = the head entry, both derived from registered state.
REQ-028 SHALL pop the FIFO at the edge where tx_valid && tx_ready.
REQ-029 SHALL, on simultaneous push and pop: leave count unchanged and accept the push, including when the FIFO is full.
REQ-030 SHALL, when the FIFO is empty, accept a push without any pop; tx_valid rises the next cycle.
REQ-031 SHALL wrap the read and write pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-032 SHALL keep tx_data stable while tx_valid && !tx_ready.

Reset
REQ-033 SHALL, while rst_n = 0, immediately set: FIFO pointers and count = 0; tx_valid = 0; tx_data = 0; err = 0; mem_data high-Z.
REQ-034 SHALL NOT clear RAM contents on reset; RAM is zero-initialised at configuration only.
REQ-035 SHALL discard a FIFO entry being pushed or popped in the cycle reset asserts.
REQ-036 SHALL process the first access on the first rising edge after rst_n deasserts.

Verification
REQ-037 SHALL cover: word write 0xDEADBEEF @0x10, then byte read @0x13 -> 0x000000DE; halfword read @0x12 -> 0x0000DEAD.
REQ-038 SHALL cover: byte write 0x55 @0x11 over 0xDEADBEEF -> word read @0x10 = 0xDEAD55EF.
REQ-039 SHALL cover: word read @0x12 -> 0, err=1; STATUS write 0x100 -> err=0; STATUS read -> 0x00000002.
REQ-040 SHALL cover: with tx_ready=0, 9 TXDATA pushes -> count=8, err=1, STATUS = 0x00000181; then tx_ready=1 -> bytes drain in push order, and tx_valid drops after 8 cycles.
REQ-041 SHALL cover: full FIFO with tx_ready=1 plus a same-cycle push -> count stays 8, err stays 0, and the new byte emerges last.
REQ-042 SHALL cover: rst_n pulled low mid-drain -> tx_valid=0 at once, err=0, and RAM contents are preserved on readback.

Source files
------------

// File: rtl/bus_responder.sv
// Memory-mapped responder: byte-addressable RAM plus a TX byte FIFO and a STATUS register.
// Reads return data in the same cycle; writes commit at the clock edge; tx_valid/tx_ready handshake on the FIFO head.
module bus_responder #(
  parameter int unsigned RAM_WORDS  = 256,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  input  logic        mem_rw,
  input  logic [1:0]  mem_size,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  logic [31:0]   ram_q  [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic          access, ram_hit, tx_hit, st_hit, misaligned, ok, bad;
  logic [AW-1:0] ram_idx;
  logic [31:0]   rword, shifted, status, src, rd_data, wdata;
  logic [3:0]    be;
  logic          ram_we, full, empty, pop, push_req, push, drop, clr;

  assign access     = (mem_size != 2'd0);
  assign ram_hit    = ({1'b0, mem_addr} < RAM_BYTES);
  assign tx_hit     = (mem_addr == MMIO_BASE);
  assign st_hit     = (mem_addr == MMIO_BASE + 32'd4);
  assign misaligned = ((mem_size == 2'd2) && mem_addr[0]) ||
                      ((mem_size == 2'd3) && (mem_addr[1:0] != 2'd0));
  assign ok         = access && !misaligned && (ram_hit || tx_hit || st_hit);
  assign bad        = access && !ok;
  assign ram_idx    = mem_addr[AW+1:2];

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign status = {23'd0, err_q, 4'(count_q), 2'd0, empty, full};

  // Read path: select the source word, shift the addressed lane down, then zero-extend by size.
  always_comb begin
    rword   = ram_q[ram_idx];
    shifted = rword >> {mem_addr[1:0], 3'b000};
    src     = 32'd0;
    rd_data = 32'd0;
    if (ok) begin
      if (ram_hit)     src = shifted;
      else if (st_hit) src = status;
      case (mem_size)
        2'd1:    rd_data = {24'd0, src[7:0]};
        2'd2:    rd_data = {16'd0, src[15:0]};
        default: rd_data = src;
      endcase
    end
  end

  assign mem_data = (access && !mem_rw) ? rd_data : 32'bz;

  always_comb begin
    be    = 4'b0000;
    wdata = mem_data;
    case (mem_size)
      2'd1: begin
        be    = 4'b0001 << mem_addr[1:0];
        wdata = {4{mem_data[7:0]}};
      end
      2'd2: begin
        be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_data[15:0]}};
      end
      2'd3:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign ram_we = ok && mem_rw && ram_hit;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && be[i]) ram_q[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign pop      = !empty && tx_ready;
  assign push_req = ok && mem_rw && tx_hit;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;
  assign clr      = ok && mem_rw && st_hit && mem_data[8];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_data[7:0];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + (pop  ? PW'(1) : PW'(0));
    wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    err_d = err_q;
    if (bad || drop) err_d = 1'b1;
    else if (clr)    err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'd0 : fifo_q[rd_ptr_q];
  assign err      = err_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: RAM lanes, error flag, TX FIFO ordering/overflow, reset.
module tb_bus_responder;

  localparam logic [31:0] MMIO = 32'hFFFF_FF00;
  localparam logic [31:0] STAT = 32'hFFFF_FF04;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  logic        tb_oe;
  logic [31:0] tb_dat;
  logic [31:0] rd;
  int          total = 0;
  int          fails = 0;

  assign mem_data = tb_oe ? tb_dat : 32'bz;

  bus_responder #(.RAM_WORDS(256), .MMIO_BASE(MMIO), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rw(mem_rw), .mem_size(mem_size), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_size = 2'd0;
    mem_rw   = 1'b0;
    tb_oe    = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    @(negedge clk);
    mem_addr = a; mem_rw = 1'b1; mem_size = sz; tb_dat = d; tb_oe = 1'b1;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, output logic [31:0] d);
    @(negedge clk);
    mem_addr = a; mem_rw = 1'b0; mem_size = sz; tb_oe = 1'b0;
    #1 d = mem_data;
    @(posedge clk);
    #1 idle();
  endtask

  initial begin
    rst_n = 1'b0; tx_ready = 1'b0; mem_addr = 32'd0; tb_dat = 32'd0;
    idle();
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // RAM lanes
    do_write(32'h10, 2'd3, 32'hDEADBEEF);
    do_read(32'h13, 2'd1, rd);  chk("byte_rd_13", rd, 32'h0000_00DE);
    do_read(32'h12, 2'd2, rd);  chk("half_rd_12", rd, 32'h0000_DEAD);
    do_read(32'h10, 2'd3, rd);  chk("word_rd_10", rd, 32'hDEAD_BEEF);
    chk("no_err_after_ram", 32'(err), 32'd0);
    do_write(32'h11, 2'd1, 32'hAAAA_AA55);
    do_read(32'h10, 2'd3, rd);  chk("byte_wr_merge", rd, 32'hDEAD_55EF);
    do_write(32'h16, 2'd2, 32'hFFFF_1234);
    do_read(32'h14, 2'd3, rd);  chk("half_wr_hi", rd, 32'h1234_0000);

    // Errors and STATUS
    do_read(32'h12, 2'd3, rd);  chk("misal_rd_zero", rd, 32'd0);
    chk("misal_rd_err", 32'(err), 32'd1);
    do_read(STAT, 2'd3, rd);    chk("status_err_set", rd, 32'h0000_0102);
    do_write(STAT, 2'd3, 32'h100);
    chk("err_cleared", 32'(err), 32'd0);
    do_read(STAT, 2'd3, rd);    chk("status_idle", rd, 32'h0000_0002);
    do_read(MMIO, 2'd3, rd);    chk("txdata_rd_zero", rd, 32'd0);
    chk("txdata_rd_noerr", 32'(err), 32'd0);
    do_write(32'h11, 2'd2, 32'hFFFF_FFFF);
    chk("misal_wr_err", 32'(err), 32'd1);
    do_read(32'h10, 2'd3, rd);  chk("misal_wr_ignored", rd, 32'hDEAD_55EF);
    do_write(STAT, 2'd3, 32'h0FF);
    chk("status_wr_no_bit8", 32'(err), 32'd1);
    do_write(STAT, 2'd3, 32'h100);
    do_read(32'h400, 2'd3, rd); chk("unmapped_rd_zero", rd, 32'd0);
    chk("unmapped_rd_err", 32'(err), 32'd1);
    do_write(STAT, 2'd3, 32'h100);

    // Overflow with stalled consumer
    for (int i = 1; i <= 9; i++) begin
      do_write(MMIO, 2'd3, 32'h100 | 32'(i));
      if (i == 8) chk("eight_push_noerr", 32'(err), 32'd0);
    end
    chk("overflow_err", 32'(err), 32'd1);
    do_read(STAT, 2'd3, rd);    chk("status_full", rd, 32'h0000_0181);
    chk("head_stall_a", 32'(tx_data), 32'h01);
    @(negedge clk); @(negedge clk);
    chk("head_stall_b", 32'(tx_data), 32'h01);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_valid_%0d", i), 32'(tx_valid), 32'd1);
      chk($sformatf("drain_data_%0d", i),  32'(tx_data),  32'(i));
      @(negedge clk);
    end
    chk("drain_done", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    do_write(STAT, 2'd3, 32'h100);

    // Full FIFO, pop and push in the same cycle
    for (int i = 0; i < 8; i++) do_write(MMIO, 2'd1, 32'h10 + 32'(i));
    @(negedge clk);
    tx_ready = 1'b1;
    mem_addr = MMIO; mem_rw = 1'b1; mem_size = 2'd3; tb_dat = 32'hAA; tb_oe = 1'b1;
    @(posedge clk);
    #1 idle();
    tx_ready = 1'b0;
    chk("pushpop_noerr", 32'(err), 32'd0);
    do_read(STAT, 2'd3, rd);    chk("pushpop_count", rd, 32'h0000_0081);
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_data_%0d", i), 32'(tx_data), (i < 7) ? 32'h11 + 32'(i) : 32'hAA);
      @(negedge clk);
    end
    chk("pp_drain_done", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Reset mid-drain
    for (int i = 0; i < 3; i++) do_write(MMIO, 2'd1, 32'h21 + 32'(i));
    do_read(32'h400, 2'd1, rd);
    chk("pre_rst_err", 32'(err), 32'd1);
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_head", 32'(tx_data), 32'h22);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_err",   32'(err),      32'd0);
    chk("mid_rst_data",  32'(tx_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b0;
    do_read(32'h10, 2'd3, rd);  chk("ram_keep_10", rd, 32'hDEAD_55EF);
    do_read(32'h14, 2'd3, rd);  chk("ram_keep_14", rd, 32'h1234_0000);
    do_read(STAT, 2'd3, rd);    chk("status_post_rst", rd, 32'h0000_0002);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
